// File: rtl/jlsemi_util_reset_sequencer.sv
// Staged reset-release sequencer with four-phase soft-reset replay.
// Optional scan bypass of stage resets: JLSEMI_RST_SEQ_SCAN_BYPASS_EN.
module jlsemi_util_reset_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int GAP_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  soft_rst_req_i,
  input  logic [GAP_W-1:0]      gap_cfg_i,
`ifdef JLSEMI_RST_SEQ_SCAN_BYPASS_EN
  input  logic                  dft_rstseq_scan_rst_ctrl,
  input  logic                  dft_rstseq_scan_rst,
`endif
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  seq_done_o,
  output logic                  soft_rst_ack_o
);

  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_SEQ  = 2'd0,
    ST_RUN  = 2'd1,
    ST_SOFT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [GAP_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    done_q, done_d;
  logic                    ack_q, ack_d;
  logic [GAP_W-1:0]        gap_eff;
  logic [GAP_W-1:0]        gap_m1;

  // A zero gap behaves like a one-cycle gap.
  always_comb begin
    gap_eff = (gap_cfg_i == '0) ? GAP_W'(1) : gap_cfg_i;
    gap_m1  = gap_eff - GAP_W'(1);
  end

  // Next-state: interval counting, staged release, soft-reset entry/exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    ack_d   = ack_q;
    case (state_q)
      ST_SEQ, ST_RUN: begin
        if (soft_rst_req_i) begin
          state_d = ST_SOFT;
          stage_d = '1;
          done_d  = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (state_q == ST_SEQ) begin
          if (cnt_q == gap_m1) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            for (int k = 0; k < NUM_STAGES; k++) begin
              if (idx_q == IDX_W'(k + 1)) stage_d[k] = 1'b0;
            end
            if (idx_q == IDX_W'(NUM_STAGES)) begin
              done_d  = 1'b1;
              state_d = ST_RUN;
            end
          end else begin
            cnt_d = cnt_q + GAP_W'(1);
          end
        end
      end
      ST_SOFT: begin
        stage_d = '1;
        if (!soft_rst_req_i) begin
          ack_d   = 1'b0;
          state_d = ST_SEQ;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_SEQ;
        cnt_d   = '0;
        idx_d   = '0;
        stage_d = '1;
        done_d  = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset holds every stage asserted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_SEQ;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '1;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

`ifdef JLSEMI_RST_SEQ_SCAN_BYPASS_EN
  // Scan mode overrides every stage reset after the registers.
  always_comb begin
    stage_rst_o = dft_rstseq_scan_rst_ctrl ?
                  {NUM_STAGES{dft_rstseq_scan_rst}} : stage_q;
  end
`else
  // Stage resets come straight from their registers.
  always_comb begin
    stage_rst_o = stage_q;
  end
`endif

  assign seq_done_o     = done_q;
  assign soft_rst_ack_o = ack_q;

endmodule

// File: tb/tb_jlsemi_util_reset_sequencer.sv
// Self-checking bench: behavioural release-time model plus directed
// timing pins and randomized soft-reset / reset / gap traffic.
module tb_jlsemi_util_reset_sequencer;

  localparam int N  = 4;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [GW-1:0] gap = 8'd3;
  logic [N-1:0]  stage;
  logic          done;
  logic          ack;
`ifdef JLSEMI_RST_SEQ_SCAN_BYPASS_EN
  logic          scan_ctrl = 1'b0;
  logic          scan_rst  = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  jlsemi_util_reset_sequencer #(
    .NUM_STAGES(N),
    .GAP_W(GW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .soft_rst_req_i(req),
    .gap_cfg_i(gap),
`ifdef JLSEMI_RST_SEQ_SCAN_BYPASS_EN
    .dft_rstseq_scan_rst_ctrl(scan_ctrl),
    .dft_rstseq_scan_rst(scan_rst),
`endif
    .stage_rst_o(stage),
    .seq_done_o(done),
    .soft_rst_ack_o(ack)
  );

  always #5 clk = ~clk;

  // Model: edges elapsed since sequence start (reset release or ack fall).
  // ph: 0 sequencing, 1 running, 2 soft reset held.
  int t  = 0;
  int ph = 0;

  function automatic int geff();
    return (gap == 0) ? 1 : int'(gap);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= 0;
      t  <= 0;
    end else if (ph == 2) begin
      if (!req) begin
        ph <= 0;
        t  <= 0;
      end
    end else if (req) begin
      ph <= 2;
    end else if (ph == 0) begin
      t <= t + 1;
      if (t + 1 >= (N + 1) * geff()) ph <= 1;
    end
  end

  function automatic logic [N-1:0] m_stage();
    logic [N-1:0] s;
    s = '0;
    if (ph == 2) s = '1;
    else if (ph == 0)
      for (int k = 0; k < N; k++) s[k] = (t < (k + 2) * geff());
`ifdef JLSEMI_RST_SEQ_SCAN_BYPASS_EN
    if (scan_ctrl) s = {N{scan_rst}};
`endif
    return s;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] es;
      logic ed, ea;
      es = m_stage();
      ed = (ph == 1);
      ea = (ph == 2);
      checks++;
      if (stage !== es || done !== ed || ack !== ea) begin
        errors++;
        $display("FAIL model_cmp @%0t stage=%b exp=%b done=%b exp=%b ack=%b exp=%b",
                 $time, stage, es, done, ed, ack, ea);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  int fall_e[N];
  int done_e;

  // Records the edge after which each stage falls, counting from edge 1.
  task automatic record_edges(input int maxe);
    for (int k = 0; k < N; k++) fall_e[k] = -1;
    done_e = -1;
    for (int e = 1; e <= maxe; e++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
        if (fall_e[k] < 0 && !stage[k]) fall_e[k] = e;
      if (done_e < 0 && done) done_e = e;
    end
  endtask

  task automatic start_seq(input int g);
    @(negedge clk);
    #1;
    rst = 1'b1;
    req = 1'b0;
    gap = GW'(g);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_falls(input string nm, input int g);
    for (int k = 0; k < N; k++)
      check($sformatf("%s_fall%0d", nm, k), fall_e[k], (k + 2) * g);
    check($sformatf("%s_done", nm), done_e, (N + 1) * g);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_stage", int'(stage), 4'hF);
    check("reset_done", int'(done), 0);
    check("reset_ack", int'(ack), 0);
    chk_en = 1'b1;

    start_seq(3);
    record_edges(20);
    check_falls("pwrup_g3", 3);

    start_seq(0);
    record_edges(8);
    check_falls("gap0", 1);
    start_seq(1);
    record_edges(8);
    check_falls("gap1", 1);

    // Soft reset from RUN, request held for 10 cycles.
    start_seq(3);
    record_edges(20);
    @(negedge clk);
    #1;
    req = 1'b1;
    check("pre_req_ack", int'(ack), 0);
    @(posedge clk);
    #1;
    check("soft_ack_rise", int'(ack), 1);
    check("soft_stage_f", int'(stage), 4'hF);
    check("soft_done_lo", int'(done), 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    #1;
    req = 1'b0;
    check("soft_ack_held", int'(ack), 1);
    @(posedge clk);
    #1;
    check("soft_ack_fall", int'(ack), 0);
    record_edges(20);
    check_falls("replay", 3);

    // Abort mid-sequence after stage 1 is released.
    start_seq(3);
    record_edges(10);
    check("abort_pre", int'(stage), 4'hC);
    @(negedge clk);
    #1;
    req = 1'b1;
    @(posedge clk);
    #1;
    check("abort_stage", int'(stage), 4'hF);
    check("abort_ack", int'(ack), 1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_done", int'(done), 0);

    // Reset pulse while in SOFT.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_stage", int'(stage), 4'hF);
    check("async_ack", int'(ack), 0);
    check("async_done", int'(done), 0);
    req = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    record_edges(20);
    check_falls("post_rst", 3);

`ifdef JLSEMI_RST_SEQ_SCAN_BYPASS_EN
    @(negedge clk);
    #1;
    scan_ctrl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      scan_rst = ~scan_rst;
      #1;
      check("scan_stage", int'(stage), scan_rst ? 4'hF : 4'h0);
      check("scan_done", int'(done), 1);
      @(negedge clk);
      #1;
    end
    scan_ctrl = 1'b0;
    #1;
    check("scan_off", int'(stage), 0);
`endif

    // Randomized traffic; gap changes only while running.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      if (rst) begin
        if ($urandom_range(2) == 0) rst = 1'b0;
      end else if ($urandom_range(300) == 0) begin
        rst = 1'b1;
        if ($urandom_range(1) == 0) gap = GW'($urandom_range(6));
      end else begin
        if (ph == 1 && !req && $urandom_range(9) == 0)
          gap = GW'($urandom_range(6));
        if (!req) begin
          if ($urandom_range(50) == 0) req = 1'b1;
        end else if ($urandom_range(3) == 0) begin
          req = 1'b0;
        end
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
